// File: rtl/peripheral_dbg_pu_or1k_biu_burst.sv
// Debug-unit bus interface for the OR1K CPU port: runs read/write bursts of up
// to MAX_BURST words, one bus transfer at a time, with error and timeout abort.
module peripheral_dbg_pu_or1k_biu_burst #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_BURST      = 16,
  parameter int ADDR_INC       = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LEN_W          = $clog2(MAX_BURST)
) (
  input  logic                  cpu_clk_i,
  input  logic                  rst_i,
  // debug-side command
  input  logic                  strobe_i,
  input  logic                  rd_wrn_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  rdy_o,
  // debug-side data
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  // status of the last or current command
  output logic                  err_o,
  output logic                  timeout_o,
  output logic [LEN_W:0]        words_done_o,
  // CPU bus
  output logic [ADDR_WIDTH-1:0] cpu_addr_o,
  output logic [DATA_WIDTH-1:0] cpu_data_o,
  input  logic [DATA_WIDTH-1:0] cpu_data_i,
  output logic                  cpu_stb_o,
  output logic                  cpu_we_o,
  input  logic                  cpu_ack_i,
  input  logic                  cpu_err_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WDATA = 2'd1;
  localparam logic [1:0] BUS   = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;

  // The wait counter only has to reach TIMEOUT_CYCLES-1 before aborting.
  localparam int TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int WAIT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]        state;
  logic [LEN_W-1:0]  remaining;
  logic [WAIT_W-1:0] wait_cnt;

  assign rdy_o         = (state == IDLE);
  assign wdata_ready_o = (state == WDATA);
  assign cpu_stb_o     = (state == BUS);
  assign rdata_valid_o = (state == RDATA);

  // NOTE: all state below is written with <= so every branch sees the
  // pre-edge values; mixing in blocking assignments here would create
  // order-dependent behaviour between simulation and synthesis.
  always_ff @(posedge cpu_clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      remaining    <= '0;
      wait_cnt     <= '0;
      err_o        <= 1'b0;
      timeout_o    <= 1'b0;
      words_done_o <= '0;
      data_o       <= '0;
      cpu_addr_o   <= '0;
      cpu_data_o   <= '0;
      cpu_we_o     <= 1'b0;
    end else begin
      // Counter is zero on every entry to BUS because it is held clear elsewhere.
      wait_cnt <= '0;

      case (state)
        IDLE: begin
          if (strobe_i) begin
            cpu_addr_o   <= addr_i;
            cpu_we_o     <= ~rd_wrn_i;
            remaining    <= len_i;
            err_o        <= 1'b0;
            timeout_o    <= 1'b0;
            words_done_o <= '0;
            state        <= rd_wrn_i ? BUS : WDATA;
          end
        end

        WDATA: begin
          if (wdata_valid_i) begin
            cpu_data_o <= wdata_i;
            state      <= BUS;
          end
        end

        BUS: begin
          if (cpu_err_i) begin
            err_o     <= 1'b1;
            remaining <= '0;
            state     <= IDLE;
          end else if (cpu_ack_i) begin
            words_done_o <= words_done_o + (LEN_W+1)'(1);
            if (!cpu_we_o) begin
              data_o <= cpu_data_i;
              state  <= RDATA;
            end else if (remaining == '0) begin
              state <= IDLE;
            end else begin
              remaining  <= remaining - LEN_W'(1);
              cpu_addr_o <= cpu_addr_o + ADDR_WIDTH'(ADDR_INC);
              state      <= WDATA;
            end
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == WAIT_W'(TMO_LAST)) begin
            timeout_o <= 1'b1;
            remaining <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        RDATA: begin
          if (rdata_ready_i) begin
            if (remaining == '0) begin
              state <= IDLE;
            end else begin
              remaining  <= remaining - LEN_W'(1);
              cpu_addr_o <= cpu_addr_o + ADDR_WIDTH'(ADDR_INC);
              state      <= BUS;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_dbg_pu_or1k_biu_burst.sv
// Directed bench for the OR1K debug BIU burst engine; bus responses are
// driven cycle by cycle from the single stimulus block.
module tb_peripheral_dbg_pu_or1k_biu_burst;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 4;

  logic          cpu_clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          strobe_i = 1'b0;
  logic          rd_wrn_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          rdy_o;
  logic [DW-1:0] wdata_i = '0;
  logic          wdata_valid_i = 1'b0;
  logic          wdata_ready_o;
  logic [DW-1:0] data_o;
  logic          rdata_valid_o;
  logic          rdata_ready_i = 1'b0;
  logic          err_o;
  logic          timeout_o;
  logic [LW:0]   words_done_o;
  logic [AW-1:0] cpu_addr_o;
  logic [DW-1:0] cpu_data_o;
  logic [DW-1:0] cpu_data_i = '0;
  logic          cpu_stb_o;
  logic          cpu_we_o;
  logic          cpu_ack_i = 1'b0;
  logic          cpu_err_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  peripheral_dbg_pu_or1k_biu_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(16),
    .ADDR_INC(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .cpu_clk_i(cpu_clk_i), .rst_i(rst_i),
    .strobe_i(strobe_i), .rd_wrn_i(rd_wrn_i), .addr_i(addr_i), .len_i(len_i),
    .rdy_o(rdy_o),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .data_o(data_o), .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
    .err_o(err_o), .timeout_o(timeout_o), .words_done_o(words_done_o),
    .cpu_addr_o(cpu_addr_o), .cpu_data_o(cpu_data_o), .cpu_data_i(cpu_data_i),
    .cpu_stb_o(cpu_stb_o), .cpu_we_o(cpu_we_o),
    .cpu_ack_i(cpu_ack_i), .cpu_err_i(cpu_err_i)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  // Advance one rising edge and settle before the next look at outputs.
  task automatic tick();
    @(posedge cpu_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rdy"},        64'(rdy_o),         64'd1);
    check({tag, " stb"},        64'(cpu_stb_o),     64'd0);
    check({tag, " wready"},     64'(wdata_ready_o), 64'd0);
    check({tag, " rvalid"},     64'(rdata_valid_o), 64'd0);
    check({tag, " err"},        64'(err_o),         64'd0);
    check({tag, " timeout"},    64'(timeout_o),     64'd0);
    check({tag, " words_done"}, 64'(words_done_o),  64'd0);
    check({tag, " data_o"},     64'(data_o),        64'd0);
    check({tag, " addr"},       64'(cpu_addr_o),    64'd0);
    check({tag, " wdata"},      64'(cpu_data_o),    64'd0);
    check({tag, " we"},         64'(cpu_we_o),      64'd0);
  endtask

  // Present a command for one edge, then drop the strobe.
  task automatic issue(input logic rd, input logic [AW-1:0] a, input logic [LW-1:0] l);
    strobe_i = 1'b1; rd_wrn_i = rd; addr_i = a; len_i = l;
    tick();
    strobe_i = 1'b0;
  endtask

  initial begin
    // ---- reset ----
    tick(); tick();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick();
    check("no stb after reset release", 64'(cpu_stb_o), 64'd0);
    check("idle after reset release", 64'(rdy_o), 64'd1);

    // ---- single read at 0x100 ----
    issue(1'b1, 32'h100, 4'd0);
    check("rd1 stb", 64'(cpu_stb_o), 64'd1);
    check("rd1 addr", 64'(cpu_addr_o), 64'h100);
    check("rd1 we", 64'(cpu_we_o), 64'd0);
    check("rd1 rdy low", 64'(rdy_o), 64'd0);
    cpu_ack_i = 1'b1; cpu_data_i = 32'hDEADBEEF;
    tick();
    cpu_ack_i = 1'b0; cpu_data_i = '0;
    check("rd1 stb dropped", 64'(cpu_stb_o), 64'd0);
    check("rd1 rvalid", 64'(rdata_valid_o), 64'd1);
    check("rd1 data", 64'(data_o), 64'hDEADBEEF);
    check("rd1 words", 64'(words_done_o), 64'd1);
    rdata_ready_i = 1'b1;
    tick();
    rdata_ready_i = 1'b0;
    check("rd1 back to idle", 64'(rdy_o), 64'd1);
    check("rd1 rvalid low", 64'(rdata_valid_o), 64'd0);

    // ---- write burst of 4 at 0x200, ack after two wait cycles ----
    issue(1'b0, 32'h200, 4'd3);
    check("wr wready", 64'(wdata_ready_o), 64'd1);
    check("wr we", 64'(cpu_we_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      wdata_valid_i = 1'b1; wdata_i = 32'(i + 1);
      tick();
      wdata_valid_i = 1'b0; wdata_i = '0;
      check($sformatf("wr%0d stb", i), 64'(cpu_stb_o), 64'd1);
      check($sformatf("wr%0d addr", i), 64'(cpu_addr_o), 64'(32'h200 + 32'(4 * i)));
      check($sformatf("wr%0d data", i), 64'(cpu_data_o), 64'(i + 1));
      tick(); tick();
      check($sformatf("wr%0d stb held", i), 64'(cpu_stb_o), 64'd1);
      check($sformatf("wr%0d addr held", i), 64'(cpu_addr_o), 64'(32'h200 + 32'(4 * i)));
      cpu_ack_i = 1'b1;
      tick();
      cpu_ack_i = 1'b0;
      check($sformatf("wr%0d words", i), 64'(words_done_o), 64'(i + 1));
      check($sformatf("wr%0d stb after ack", i), 64'(cpu_stb_o), 64'd0);
    end
    check("wr done idle", 64'(rdy_o), 64'd1);
    check("wr done we", 64'(cpu_we_o), 64'd1);

    // ---- read burst of 8 aborted by error on the 3rd word ----
    issue(1'b1, 32'h300, 4'd7);
    check("err first words clear", 64'(words_done_o), 64'd0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("err rd%0d addr", i), 64'(cpu_addr_o), 64'(32'h300 + 32'(4 * i)));
      cpu_ack_i = 1'b1; cpu_data_i = 32'hA0 + 32'(i);
      tick();
      cpu_ack_i = 1'b0;
      check($sformatf("err rd%0d data", i), 64'(data_o), 64'(32'hA0 + 32'(i)));
      rdata_ready_i = 1'b1;
      tick();
      rdata_ready_i = 1'b0;
    end
    check("err 3rd addr", 64'(cpu_addr_o), 64'h308);
    cpu_err_i = 1'b1; cpu_ack_i = 1'b1;
    tick();
    cpu_err_i = 1'b0; cpu_ack_i = 1'b0;
    check("err flag", 64'(err_o), 64'd1);
    check("err words", 64'(words_done_o), 64'd2);
    check("err rdy", 64'(rdy_o), 64'd1);
    check("err stb", 64'(cpu_stb_o), 64'd0);
    tick();
    check("err no further stb", 64'(cpu_stb_o), 64'd0);
    check("err flag held", 64'(err_o), 64'd1);

    // ---- timeout: no ack for 8 cycles ----
    issue(1'b1, 32'h400, 4'd0);
    check("tmo err cleared", 64'(err_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tmo stb cycle %0d", i + 1), 64'(cpu_stb_o), 64'd1);
      tick();
    end
    check("tmo stb dropped", 64'(cpu_stb_o), 64'd0);
    check("tmo flag", 64'(timeout_o), 64'd1);
    check("tmo rdy", 64'(rdy_o), 64'd1);
    check("tmo words", 64'(words_done_o), 64'd0);

    // ---- ack in the 8th cycle wins; strobes while busy are ignored ----
    issue(1'b1, 32'h400, 4'd0);
    check("tmo2 flag cleared", 64'(timeout_o), 64'd0);
    strobe_i = 1'b1; rd_wrn_i = 1'b0; addr_i = 32'hABC;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("tmo2 stb cycle %0d", i + 1), 64'(cpu_stb_o), 64'd1);
      tick();
    end
    check("tmo2 addr unaffected by strobe", 64'(cpu_addr_o), 64'h400);
    check("tmo2 we unaffected by strobe", 64'(cpu_we_o), 64'd0);
    strobe_i = 1'b0;
    check("tmo2 stb cycle 8", 64'(cpu_stb_o), 64'd1);
    cpu_ack_i = 1'b1; cpu_data_i = 32'h55;
    tick();
    cpu_ack_i = 1'b0;
    check("tmo2 rvalid", 64'(rdata_valid_o), 64'd1);
    check("tmo2 data", 64'(data_o), 64'h55);
    check("tmo2 no timeout", 64'(timeout_o), 64'd0);
    rdata_ready_i = 1'b1;
    tick();
    rdata_ready_i = 1'b0;
    check("tmo2 idle", 64'(rdy_o), 64'd1);
    check("tmo2 words", 64'(words_done_o), 64'd1);

    // ---- address wrap with read backpressure ----
    issue(1'b1, 32'hFFFF_FFFC, 4'd1);
    check("wrap addr0", 64'(cpu_addr_o), 64'hFFFF_FFFC);
    cpu_ack_i = 1'b1; cpu_data_i = 32'h1111_2222;
    tick();
    cpu_ack_i = 1'b0; cpu_data_i = 32'h9999_9999;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wrap hold data %0d", i), 64'(data_o), 64'h1111_2222);
      check($sformatf("wrap hold rvalid %0d", i), 64'(rdata_valid_o), 64'd1);
      tick();
    end
    rdata_ready_i = 1'b1;
    tick();
    rdata_ready_i = 1'b0;
    check("wrap stb", 64'(cpu_stb_o), 64'd1);
    check("wrap addr1", 64'(cpu_addr_o), 64'h0);
    cpu_ack_i = 1'b1; cpu_data_i = 32'h33;
    tick();
    cpu_ack_i = 1'b0;
    check("wrap data1", 64'(data_o), 64'h33);
    check("wrap words", 64'(words_done_o), 64'd2);
    rdata_ready_i = 1'b1;
    tick();
    rdata_ready_i = 1'b0;
    check("wrap idle", 64'(rdy_o), 64'd1);

    // ---- reset in WDATA ----
    issue(1'b0, 32'h500, 4'd2);
    check("rstw in wdata", 64'(wdata_ready_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_outputs("rst in wdata");

    // ---- reset in BUS ----
    issue(1'b0, 32'h500, 4'd2);
    wdata_valid_i = 1'b1; wdata_i = 32'h77;
    tick();
    wdata_valid_i = 1'b0;
    check("rstb in bus", 64'(cpu_stb_o), 64'd1);
    check("rstb bus data", 64'(cpu_data_o), 64'h77);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_outputs("rst in bus");

    // ---- fresh command after reset ----
    issue(1'b0, 32'h600, 4'd0);
    wdata_valid_i = 1'b1; wdata_i = 32'h88;
    tick();
    wdata_valid_i = 1'b0;
    check("post rst addr", 64'(cpu_addr_o), 64'h600);
    check("post rst data", 64'(cpu_data_o), 64'h88);
    check("post rst we", 64'(cpu_we_o), 64'd1);
    cpu_ack_i = 1'b1;
    tick();
    cpu_ack_i = 1'b0;
    check("post rst idle", 64'(rdy_o), 64'd1);
    check("post rst words", 64'(words_done_o), 64'd1);
    check("post rst err", 64'(err_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
